// File: rtl/pal_pkg.sv
// rtl/pal_pkg.sv - shared PAL configuration types, constants and chain-length helper
package pal_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Chain length is shared with the PAL instance so both sides agree on the bit count.
  function automatic int cfg_bits(input int n, input int p, input int m);
    return 2 * n * p + p * m;
  endfunction

endpackage

// File: rtl/pal_cfg_loader_if.sv
// rtl/pal_cfg_loader_if.sv - configuration byte valid/ready handshake
interface pal_cfg_loader_if;
  import pal_pkg::*;

  logic [BYTE_W-1:0] DATA_IN;
  logic              DATA_VALID;
  logic              DATA_READY;

  modport master (output DATA_IN, output DATA_VALID, input DATA_READY);
  modport slave  (input DATA_IN, input DATA_VALID, output DATA_READY);

endinterface

// File: rtl/pal_cfg_piso.sv
// rtl/pal_cfg_piso.sv - byte-wide parallel-in/serial-out register, MSB first
module pal_cfg_piso
  import pal_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] din,
  output logic              msb
);

  logic [BYTE_W-1:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[BYTE_W-2:0], 1'b0};
    end
  end

  assign msb = shreg[BYTE_W-1];

endmodule

// File: rtl/pal_cfg_loader.sv
// rtl/pal_cfg_loader.sv - serialises configuration bytes onto the PAL CFG shift chain
module pal_cfg_loader
  import pal_pkg::*;
#(
  parameter int N        = 8,
  parameter int P        = 8,
  parameter int M        = 8,
  parameter int CFG_BITS = cfg_bits(N, P, M),
  parameter int CNT_W    = $clog2(CFG_BITS + 1)
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             START,
  input  logic             ABORT,
  pal_cfg_loader_if.slave  dbus,
  output logic             CFG_OUT,
  output logic             CFG_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] BITS_SENT
);

  state_t      state;
  logic [3:0]  byte_left;
  logic [3:0]  first_bits;
  logic [31:0] remaining;
  logic        piso_load;
  logic        piso_shift;
  logic        piso_msb;

  assign dbus.DATA_READY = (state == LOAD);
  assign BUSY            = (state != IDLE);
  assign piso_load       = (state == LOAD) && dbus.DATA_VALID && !ABORT;
  assign piso_shift      = (state == SHIFT) && !ABORT;

  // A short final byte only sends its upper bits; the rest stay in the register and are dropped.
  assign remaining = CFG_BITS - 32'(BITS_SENT);
  always_comb begin
    first_bits = 4'd8;
    if (remaining < 32'd8) first_bits = remaining[3:0];
  end

  pal_cfg_piso u_piso (
    .clk   (CLK),
    .rst   (RES),
    .load  (piso_load),
    .shift (piso_shift),
    .din   (dbus.DATA_IN),
    .msb   (piso_msb)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state     <= IDLE;
      byte_left <= 4'd0;
      BITS_SENT <= '0;
      CFG_OUT   <= 1'b0;
      CFG_EN    <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      CFG_OUT <= 1'b0;
      CFG_EN  <= 1'b0;
      DONE    <= 1'b0;
      if (ABORT && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (START) begin
              state     <= LOAD;
              BITS_SENT <= '0;
            end
          end
          LOAD: begin
            if (dbus.DATA_VALID) begin
              byte_left <= first_bits;
              state     <= SHIFT;
            end
          end
          SHIFT: begin
            CFG_OUT   <= piso_msb;
            CFG_EN    <= 1'b1;
            BITS_SENT <= BITS_SENT + CNT_W'(1);
            byte_left <= byte_left - 4'd1;
            if (byte_left == 4'd1) begin
              if ((BITS_SENT + CNT_W'(1)) == CNT_W'(CFG_BITS)) begin
                state <= FINISH;
                DONE  <= 1'b1;
              end else begin
                state <= LOAD;
              end
            end
          end
          FINISH: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
